// File: rtl/poly_oscillator_if.sv
// poly_oscillator_if: groups the per-channel control and output vectors of poly_oscillator.
//   master : drives en, retrig and divider; receives count, wrap and square
//            (the note/key decoder side, or a testbench).
//   slave  : the oscillator block itself.
// Channel i of every vector occupies bit i (1-bit signals) or bits [i*WIDTH +: WIDTH] (count and
// divider).
interface poly_oscillator_if #(
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned WIDTH    = 16
);
    logic [CHANNELS-1:0]       en;
    logic [CHANNELS-1:0]       retrig;
    logic [CHANNELS*WIDTH-1:0] divider;
    logic [CHANNELS*WIDTH-1:0] count;
    logic [CHANNELS-1:0]       wrap;
    logic [CHANNELS-1:0]       square;

    modport master (
        output en,
        output retrig,
        output divider,
        input  count,
        input  wrap,
        input  square
    );

    modport slave (
        input  en,
        input  retrig,
        input  divider,
        output count,
        output wrap,
        output square
    );
endinterface

// File: rtl/poly_oscillator.sv
// poly_oscillator: CHANNELS independent period counters. Each channel counts 1..divider,
// pulses wrap for one cycle at every period boundary and toggles square on each wrap, giving a
// 50 % duty square wave at clk/(2*divider).
// Ports:
//   clk  : system clock, all state updates on the rising edge
//   rst  : synchronous active-high reset, clears every channel
//   bus  : poly_oscillator_if slave modport
//          en/retrig/divider in (per channel), count/wrap/square out (registered)
module poly_oscillator #(
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned WIDTH    = 16
) (
    input logic              clk,
    input logic              rst,
    poly_oscillator_if.slave bus
);

    logic [WIDTH-1:0]    div_w   [CHANNELS];
    logic [WIDTH-1:0]    count_q [CHANNELS];
    logic [WIDTH-1:0]    count_d [CHANNELS];
    logic [CHANNELS-1:0] wrap_q;
    logic [CHANNELS-1:0] wrap_d;
    logic [CHANNELS-1:0] square_q;
    logic [CHANNELS-1:0] square_d;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        assign div_w[g]                     = bus.divider[g*WIDTH +: WIDTH];
        assign bus.count[g*WIDTH +: WIDTH]  = count_q[g];
    end

    assign bus.wrap   = wrap_q;
    assign bus.square = square_q;

    // Per-channel next state, in priority order: idle divider, retrigger, enable hold,
    // period boundary, increment.
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            count_d[i]  = count_q[i];
            wrap_d[i]   = 1'b0;
            square_d[i] = square_q[i];

            if (div_w[i] == '0) begin
                count_d[i]  = '0;
                square_d[i] = 1'b0;
            end else if (bus.retrig[i]) begin
                count_d[i]  = WIDTH'(1);
                square_d[i] = 1'b0;
            end else if (bus.en[i]) begin
                // >= so a divider lowered below the running count wraps at once; count==0
                // (fresh start) loads 1 without a wrap.
                if (count_q[i] != '0 && count_q[i] >= div_w[i]) begin
                    count_d[i]  = WIDTH'(1);
                    wrap_d[i]   = 1'b1;
                    square_d[i] = ~square_q[i];
                end else begin
                    count_d[i] = count_q[i] + WIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < CHANNELS; i++) begin
                count_q[i] <= '0;
            end
            wrap_q   <= '0;
            square_q <= '0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                count_q[i] <= count_d[i];
            end
            wrap_q   <= wrap_d;
            square_q <= square_d;
        end
    end

endmodule

// File: tb/tb_poly_oscillator.sv
// tb_poly_oscillator: scoreboard bench for poly_oscillator. The driver applies inputs on the
// falling edge, advances a behavioural per-channel model and queues the expected outputs; a
// monitor pops and compares one entry after every rising edge. Directed scenarios add a few
// hard-coded expectations on top.
module tb_poly_oscillator;

    localparam int CH = 4;
    localparam int W  = 16;

    typedef struct packed {
        logic [CH*W-1:0] count;
        logic [CH-1:0]   wrap;
        logic [CH-1:0]   square;
    } exp_t;

    logic tb_clk = 1'b0;
    logic tb_rst;

    poly_oscillator_if #(.CHANNELS(CH), .WIDTH(W)) bus ();

    poly_oscillator #(
        .CHANNELS(CH),
        .WIDTH   (W)
    ) dut (
        .clk(tb_clk),
        .rst(tb_rst),
        .bus(bus)
    );

    always #50 tb_clk = ~tb_clk;

    int checks = 0;
    int errors = 0;

    exp_t exp_q[$];

    // Stimulus for the next edge.
    bit          s_rst;
    bit [CH-1:0] s_en;
    bit [CH-1:0] s_retrig;
    int          s_div[CH];

    // Reference model state.
    int          m_count[CH];
    bit [CH-1:0] m_wrap;
    bit [CH-1:0] m_sq;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            if (errors <= 30)
                $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    function automatic int dut_count(input int i);
        return int'(bus.count[i*W +: W]);
    endfunction

    // One rising edge of the specified behaviour, all channels.
    task automatic model_edge();
        for (int i = 0; i < CH; i++) begin
            if (s_rst || s_div[i] == 0) begin
                m_count[i] = 0;
                m_wrap[i]  = 1'b0;
                m_sq[i]    = 1'b0;
            end else if (s_retrig[i]) begin
                m_count[i] = 1;
                m_wrap[i]  = 1'b0;
                m_sq[i]    = 1'b0;
            end else if (!s_en[i]) begin
                m_wrap[i]  = 1'b0;
            end else if (m_count[i] != 0 && m_count[i] >= s_div[i]) begin
                m_count[i] = 1;
                m_wrap[i]  = 1'b1;
                m_sq[i]    = ~m_sq[i];
            end else begin
                m_count[i] = m_count[i] + 1;
                m_wrap[i]  = 1'b0;
            end
        end
    endtask

    // Apply stimulus, queue the expectation, return just after the edge.
    task automatic step();
        exp_t e;
        @(negedge tb_clk);
        tb_rst     = s_rst;
        bus.en     = s_en;
        bus.retrig = s_retrig;
        for (int i = 0; i < CH; i++) bus.divider[i*W +: W] = W'(s_div[i]);
        model_edge();
        for (int i = 0; i < CH; i++) e.count[i*W +: W] = W'(m_count[i]);
        e.wrap   = m_wrap;
        e.square = m_sq;
        exp_q.push_back(e);
        @(posedge tb_clk);
        #1;
    endtask

    task automatic do_reset();
        s_rst    = 1'b1;
        s_retrig = '0;
        step();
        s_rst    = 1'b0;
    endtask

    // Monitor: every rising edge produces one output set to compare.
    initial begin
        exp_t e;
        forever begin
            @(posedge tb_clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                for (int i = 0; i < CH; i++) begin
                    chk($sformatf("sb_count[%0d]", i), dut_count(i), int'(e.count[i*W +: W]));
                    chk($sformatf("sb_wrap[%0d]", i), int'(bus.wrap[i]), int'(e.wrap[i]));
                    chk($sformatf("sb_square[%0d]", i), int'(bus.square[i]), int'(e.square[i]));
                end
            end
        end
    end

    initial begin
        int exp_c[7] = '{1, 2, 3, 1, 2, 3, 1};
        int exp_w[7] = '{0, 0, 0, 1, 0, 0, 1};
        int exp_s[7] = '{0, 0, 0, 1, 1, 1, 0};
        int first0;
        int first1;

        tb_rst      = 1'b1;
        bus.en      = '0;
        bus.retrig  = '0;
        bus.divider = '0;
        s_rst       = 1'b1;
        s_en        = '0;
        s_retrig    = '0;
        for (int i = 0; i < CH; i++) begin
            s_div[i]   = 0;
            m_count[i] = 0;
        end
        m_wrap = '0;
        m_sq   = '0;

        // Reset held two edges with everything enabled.
        s_en = '1;
        for (int i = 0; i < CH; i++) s_div[i] = 5;
        step();
        step();
        for (int i = 0; i < CH; i++) begin
            chk("rst_count", dut_count(i), 0);
            chk("rst_wrap", int'(bus.wrap[i]), 0);
            chk("rst_square", int'(bus.square[i]), 0);
        end
        s_rst = 1'b0;
        step();
        for (int i = 0; i < CH; i++) begin
            chk("release_count", dut_count(i), 1);
            chk("release_wrap", int'(bus.wrap[i]), 0);
        end

        // Period 3 on channel 0.
        do_reset();
        s_div = '{3, 7, 2, 5};
        for (int k = 0; k < 7; k++) begin
            step();
            chk("p3_count", dut_count(0), exp_c[k]);
            chk("p3_wrap", int'(bus.wrap[0]), exp_w[k]);
            chk("p3_square", int'(bus.square[0]), exp_s[k]);
        end

        // Independent channels with long, unit and idle dividers.
        do_reset();
        s_div  = '{22727, 30000, 1, 0};
        first0 = -1;
        first1 = -1;
        for (int n = 1; n <= 30001; n++) begin
            step();
            if (bus.wrap[0] && first0 < 0) first0 = n;
            if (bus.wrap[1] && first1 < 0) first1 = n;
        end
        chk("ch0_first_wrap", first0, 22728);
        chk("ch1_first_wrap", first1, 30001);
        chk("ch2_wrap", int'(bus.wrap[2]), 1);
        chk("ch2_count", dut_count(2), 1);
        chk("ch3_count", dut_count(3), 0);

        // Enable hold at count 6.
        do_reset();
        s_div = '{10, 10, 10, 10};
        repeat (6) step();
        chk("hold_start", dut_count(0), 6);
        s_en = '0;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("hold_count", dut_count(0), 6);
            chk("hold_wrap", int'(bus.wrap[0]), 0);
            chk("hold_square", int'(bus.square[0]), 0);
        end
        s_en = '1;
        step();
        chk("hold_resume", dut_count(0), 7);

        // Retrigger beats a pending wrap, and works with en low.
        do_reset();
        s_div = '{4, 4, 4, 4};
        repeat (8) step();
        chk("rt_pre_count", dut_count(0), 4);
        chk("rt_pre_square", int'(bus.square[0]), 1);
        s_retrig = '1;
        step();
        chk("rt_count", dut_count(0), 1);
        chk("rt_wrap", int'(bus.wrap[0]), 0);
        chk("rt_square", int'(bus.square[0]), 0);
        s_retrig = '0;
        step();
        chk("rt_next", dut_count(0), 2);
        s_en     = '0;
        s_retrig = '1;
        step();
        chk("rt_en0_count", dut_count(0), 1);
        s_en     = '1;
        s_retrig = '0;

        // Divider shrink below the running count.
        do_reset();
        s_div = '{100, 100, 100, 100};
        repeat (50) step();
        chk("shrink_pre", dut_count(0), 50);
        s_div = '{20, 20, 20, 20};
        step();
        chk("shrink_count", dut_count(0), 1);
        chk("shrink_wrap", int'(bus.wrap[0]), 1);
        chk("shrink_square", int'(bus.square[0]), 1);
        repeat (19) step();
        chk("shrink_p20_count", dut_count(0), 20);
        chk("shrink_p20_nowrap", int'(bus.wrap[0]), 0);
        step();
        chk("shrink_p20_wrap", int'(bus.wrap[0]), 1);
        chk("shrink_p20_square", int'(bus.square[0]), 0);

        // Random traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            s_rst = ($urandom_range(0, 99) == 0);
            for (int i = 0; i < CH; i++) begin
                if ($urandom_range(0, 19) == 0)
                    s_div[i] = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 12));
                s_en[i]     = ($urandom_range(0, 4) != 0);
                s_retrig[i] = ($urandom_range(0, 29) == 0);
            end
            step();
        end

        #1;
        chk("queue_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
